// File: rtl/mem_copy_dma.sv
// Single-channel word copy engine: streams len words from src to dst through a
// synchronous dual-port memory, picking copy direction so overlapping ranges move safely.
module mem_copy_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic                  oea,
  output logic                  wea,
  input  logic [31:0]           qa,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic                  web,
  output logic                  oeb,
  output logic [31:0]           db
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_reg;
  logic                  desc_reg;
  logic                  rd_pend_reg;
  logic [LEN_WIDTH-1:0]  rd_left_reg;
  logic [LEN_WIDTH-1:0]  wr_left_reg;
  logic [ADDR_WIDTH-1:0] wr_addr_reg;

  logic [ADDR_WIDTH-1:0] last_off;
  logic                  start_desc;

  assign last_off   = ADDR_WIDTH'(len) - ADDR_WIDTH'(1);
  // Copying toward higher addresses must start at the top so overlapping source words are read first.
  assign start_desc = (dst_addr > src_addr);

  assign wea = 1'b0;
  assign oeb = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      desc_reg    <= 1'b0;
      rd_pend_reg <= 1'b0;
      rd_left_reg <= '0;
      wr_left_reg <= '0;
      wr_addr_reg <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      addra       <= '0;
      oea         <= 1'b0;
      addrb       <= '0;
      web         <= 1'b0;
      db          <= '0;
    end else begin
      done        <= 1'b0;
      rd_pend_reg <= oea;
      web         <= rd_pend_reg;

      // qa now carries the word read last cycle; present it as the write for next cycle.
      if (rd_pend_reg) begin
        db          <= qa;
        addrb       <= wr_addr_reg;
        wr_addr_reg <= desc_reg ? wr_addr_reg - ADDR_WIDTH'(1) : wr_addr_reg + ADDR_WIDTH'(1);
        wr_left_reg <= wr_left_reg - LEN_WIDTH'(1);
        if (wr_left_reg == LEN_WIDTH'(1)) begin
          done <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state_reg   <= RUN;
              busy        <= 1'b1;
              oea         <= 1'b1;
              desc_reg    <= start_desc;
              addra       <= start_desc ? src_addr + last_off : src_addr;
              wr_addr_reg <= start_desc ? dst_addr + last_off : dst_addr;
              rd_left_reg <= len - LEN_WIDTH'(1);
              wr_left_reg <= len;
            end
          end
        end
        RUN: begin
          if (rd_left_reg != '0) begin
            addra       <= desc_reg ? addra - ADDR_WIDTH'(1) : addra + ADDR_WIDTH'(1);
            rd_left_reg <= rd_left_reg - LEN_WIDTH'(1);
          end else begin
            oea       <= 1'b0;
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: memory model, memmove reference, and a scoreboard monitor
// that checks every read address and write (address, data) the DUT issues.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, oea, wea, web, oeb;
  logic [31:0] addra, addrb, db;
  logic [31:0] qa = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rd_q[$];
  logic [63:0] wr_q[$];

  mem_copy_dma #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done),
    .addra(addra), .oea(oea), .wea(wea), .qa(qa),
    .addrb(addrb), .web(web), .oeb(oeb), .db(db)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return fill(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return fill(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: read data appears the cycle after oea, writes land at the edge.
  always @(posedge clk) begin
    if (oea) qa <= mem_rd(addra);
    if (web) mem[addrb] = db;
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check("wea_tied", {63'd0, wea}, 64'd0);
      check("oeb_tied", {63'd0, oeb}, 64'd0);
      if (oea) begin
        check("read_expected", {63'd0, rd_q.size() != 0}, 64'd1);
        if (rd_q.size() != 0) check("read_addr", {32'd0, addra}, {32'd0, rd_q.pop_front()});
      end
      if (web) begin
        check("db_known", {63'd0, $isunknown(db)}, 64'd0);
        check("write_expected", {63'd0, wr_q.size() != 0}, 64'd1);
        if (wr_q.size() != 0) check("write_addr_data", {addrb, db}, wr_q.pop_front());
      end
      if (oea && web) check("port_collision", {63'd0, addra == addrb}, 64'd0);
    end
  end

  // Called just after a rising edge; start is sampled on the very next edge.
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit inject);
    logic [31:0] tmp[$];
    bit desc;
    int cyc;
    int idx;
    desc = (d > s);
    for (int i = 0; i < n; i++) tmp.push_back(ref_rd(s + 32'(i)));
    for (int k = 0; k < n; k++) begin
      idx = desc ? n - 1 - k : k;
      rd_q.push_back(s + 32'(idx));
      wr_q.push_back({d + 32'(idx), tmp[idx]});
    end
    for (int i = 0; i < n; i++) ref_mem[d + 32'(i)] = tmp[i];

    start = 1'b1; src_addr = s; dst_addr = d; len = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      check("len0_done", {63'd0, done}, 64'd1);
      check("len0_busy", {63'd0, busy}, 64'd0);
      check("len0_oea_web", {62'd0, oea, web}, 64'd0);
      @(posedge clk); #1;
      check("len0_done_clear", {63'd0, done}, 64'd0);
      check("len0_busy_after", {63'd0, busy}, 64'd0);
      $display("copy src=%h dst=%h len=0 -> immediate done", s, d);
      return;
    end
    check("busy_first_run", {63'd0, busy}, 64'd1);
    cyc = 1;
    while (!done && cyc < n + 20) begin
      start = inject && (cyc == 2);
      if (start) begin
        src_addr = $urandom; dst_addr = $urandom; len = 16'($urandom_range(1, 9));
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    check("done_cycle", 64'(cyc), 64'(n + 2));
    check("busy_at_done", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    rd_q.delete(); wr_q.delete();
    for (int i = 0; i < n; i++)
      check("mem_result", {32'd0, mem_rd(d + 32'(i))}, {32'd0, ref_rd(d + 32'(i))});
    $display("copy src=%h dst=%h len=%0d %s done_cycle=%0d", s, d, n,
             desc ? "desc" : "asc", cyc);
  endtask

  initial begin
    // Reset state (asynchronous, so visible before any edge).
    #1;
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("rst_enables", {60'd0, oea, wea, web, oeb}, 64'd0);
    check("rst_addrs", {addra, addrb}, 64'd0);
    check("rst_db", {32'd0, db}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    do_copy(32'h10, 32'h40, 4, 1'b0);
    do_copy(32'h20, 32'h22, 8, 1'b0);
    do_copy(32'h22, 32'h20, 8, 1'b0);
    do_copy(32'h30, 32'h80, 0, 1'b0);
    do_copy(32'h50, 32'h60, 6, 1'b1);
    do_copy(32'hFFFF_FFFE, 32'h100, 4, 1'b0);

    // Reset mid-copy: only the first reads may appear, never a write.
    for (int i = 0; i < 4; i++) rd_q.push_back(32'hFFFF_FFFE + 32'(i));
    start = 1'b1; src_addr = 32'hFFFF_FFFE; dst_addr = 32'h200; len = 16'd4;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_web", {63'd0, web}, 64'd0);
    check("midrst_oea", {63'd0, oea}, 64'd0);
    check("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", {62'd0, done, web}, 64'd0);
    end
    rd_q.delete(); wr_q.delete();
    for (int i = 0; i < 4; i++)
      check("midrst_dst_untouched", {32'd0, mem_rd(32'h200 + 32'(i))}, {32'd0, ref_rd(32'h200 + 32'(i))});
    $display("copy src=fffffffe dst=00000200 len=4 aborted by reset");
    @(posedge clk); #1 reset = 1'b0;
    do_copy(32'h30, 32'h38, 5, 1'b0);

    for (int t = 0; t < 20; t++)
      do_copy(32'($urandom_range(0, 63)), 32'($urandom_range(0, 63)),
              int'($urandom_range(0, 12)), bit'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
